// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving a valid/ready data-memory port
// Aligns store lanes/strobes, extends loads, and stalls the pipe while an access is in flight.
module mem_stage_lsu #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction_M,
   input  logic [31:0] ALUResult_M,
   input  logic [31:0] writeData_M,
   input  logic        memWrite_M,
   input  logic [1:0]  resultSrc_M,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rsp_rdata,
   output logic        stall_M,
   output logic [31:0] readData_M,
   output logic        access_fault_M,
   output logic        timeout_M
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int            CW          = (MAX_WAIT > 255) ? $clog2(MAX_WAIT + 1) : 8;
   localparam logic [CW-1:0] LP_MAX_WAIT = CW'(MAX_WAIT);
   localparam logic          LP_TMO_EN   = (MAX_WAIT != 0);

   logic [1:0]    r_state;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wstrb;
   logic [2:0]    r_funct3;
   logic [1:0]    r_off;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_read_data;
   logic          r_timeout;

   logic [2:0]    w_funct3;
   logic [1:0]    w_off;
   logic          w_is_store;
   logic          w_is_load;
   logic          w_access;
   logic          w_legal_f3;
   logic          w_misaligned;
   logic          w_fault;
   logic          w_start;
   logic [31:0]   w_st_wdata;
   logic [3:0]    w_st_wstrb;
   logic [7:0]    w_ld_byte;
   logic [15:0]   w_ld_half;
   logic [31:0]   w_ld_ext;
   logic [CW-1:0] w_cnt_next;
   logic          w_expire;
   logic          w_unused;

   assign w_funct3   = instruction_M[14:12];
   assign w_off      = ALUResult_M[1:0];
   // A store wins when both store and load markers are set.
   assign w_is_store = memWrite_M;
   assign w_is_load  = ~memWrite_M & (resultSrc_M == 2'b01);
   assign w_access   = w_is_store | w_is_load;
   assign w_unused   = &{1'b0, instruction_M[31:15], instruction_M[11:0]};

   always_comb begin
      w_legal_f3 = 1'b0;
      if (w_is_store) begin
         w_legal_f3 = (w_funct3 == 3'd0) || (w_funct3 == 3'd1) || (w_funct3 == 3'd2);
      end else begin
         case (w_funct3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_legal_f3 = 1'b1;
            default:                      w_legal_f3 = 1'b0;
         endcase
      end
   end

   assign w_misaligned = ((w_funct3[1:0] == 2'b01) && w_off[0]) ||
                         ((w_funct3[1:0] == 2'b10) && (w_off != 2'b00));
   assign w_fault      = w_access & (~w_legal_f3 | w_misaligned);
   assign w_start      = (r_state == S_IDLE) & w_access & ~w_fault;

   always_comb begin
      w_st_wdata = writeData_M;
      w_st_wstrb = 4'b1111;
      case (w_funct3[1:0])
         2'b00: begin
            w_st_wdata = {4{writeData_M[7:0]}};
            w_st_wstrb = 4'b0001 << w_off;
         end
         2'b01: begin
            w_st_wdata = {2{writeData_M[15:0]}};
            w_st_wstrb = w_off[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   assign w_ld_byte = dmem_rsp_rdata[{r_off, 3'b000} +: 8];
   assign w_ld_half = dmem_rsp_rdata[{r_off[1], 4'b0000} +: 16];

   always_comb begin
      case (r_funct3)
         3'd0:    w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'd1:    w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
         3'd4:    w_ld_ext = {24'd0, w_ld_byte};
         3'd5:    w_ld_ext = {16'd0, w_ld_half};
         default: w_ld_ext = dmem_rsp_rdata;
      endcase
   end

   assign w_cnt_next = r_cnt + CW'(1);
   assign w_expire   = LP_TMO_EN && (w_cnt_next == LP_MAX_WAIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_wstrb     <= 4'd0;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
         r_cnt       <= '0;
         r_read_data <= 32'd0;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_we     <= w_is_store;
                  r_addr   <= {ALUResult_M[31:2], 2'b00};
                  r_wdata  <= w_is_store ? w_st_wdata : 32'd0;
                  r_wstrb  <= w_is_store ? w_st_wstrb : 4'd0;
                  r_funct3 <= w_funct3;
                  r_off    <= w_off;
                  r_cnt    <= '0;
                  r_state  <= S_REQ;
               end else if (access_fault_M) begin
                  r_read_data <= 32'd0;
               end
            end
            S_REQ: begin
               if (dmem_req_ready) begin
                  r_cnt   <= '0;
                  r_state <= r_we ? S_DONE : S_RESP;
               end else if (w_expire) begin
                  r_timeout   <= 1'b1;
                  r_read_data <= 32'd0;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            S_RESP: begin
               if (dmem_rsp_valid) begin
                  r_read_data <= w_ld_ext;
                  r_state     <= S_DONE;
               end else if (w_expire) begin
                  r_timeout   <= 1'b1;
                  r_read_data <= 32'd0;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dmem_req_valid = (r_state == S_REQ);
   assign dmem_we        = dmem_req_valid & r_we;
   assign dmem_wstrb     = dmem_req_valid ? r_wstrb : 4'd0;
   assign dmem_addr      = r_addr;
   assign dmem_wdata     = r_wdata;
   assign stall_M        = w_start | (r_state == S_REQ) | (r_state == S_RESP);
   assign access_fault_M = (r_state == S_IDLE) & w_fault;
   assign readData_M     = r_read_data;
   assign timeout_M      = r_timeout;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline. Consumes the MEM-stage signals produced by the EX/MEM pipeline register and acts as the initiator toward the data memory through a valid/ready request and response interface. It performs byte-lane alignment, store strobes and load sign/zero extension. It also asserts `stall_M` to the hazard unit while a bus access is outstanding.

## Interface
- `MAX_WAIT`, default 255: cycles allowed in REQ or RESP before the access is aborted with a timeout.
- `clk  in  1`: clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `instruction_M  in  32`: MEM-stage instruction; only funct3 `[14:12]` is used.
- `ALUResult_M  in  32`: effective byte address.
- `writeData_M  in  32`: store data, right-aligned.
- `memWrite_M  in  1`: store request.
- `resultSrc_M  in  2`: `2'b01` marks a load.
- `dmem_req_valid  out  1`: request valid.
- `dmem_req_ready  in  1`: memory accepts the request.
- `dmem_we  out  1`: 1 = write.
- `dmem_addr  out  32`: word-aligned address, `{ALUResult_M[31:2],2'b00}`.
- `dmem_wdata  out  32`: lane-replicated store data.
- `dmem_wstrb  out  4`: byte strobes; 0 on reads.
- `dmem_rsp_valid  in  1`: read data valid.
- `dmem_rsp_rdata  in  32`: read data word.
- `stall_M  out  1`: hold PC, IF/ID, ID/EX and EX/MEM.
- `readData_M  out  32`: aligned, extended load result.
- `access_fault_M  out  1`: misaligned access or illegal funct3; one-cycle pulse.
- `timeout_M  out  1`: access aborted after `MAX_WAIT` cycles; one-cycle pulse.

## Operation
- An access is present when `memWrite_M` = 1 (store) or `resultSrc_M` = 01 (load). If both are set, the access is a store.
- Legal loads: funct3 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU). Legal stores: funct3 0 (SB), 1 (SH), 2 (SW).
- Misalignment: halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
- Faulting access (illegal funct3 or misaligned):
  - No bus request is issued; no state change.
  - `access_fault_M` = 1 combinationally in IDLE; `stall_M` = 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - A legal access asserts `stall_M` combinationally.
  - On the clock edge, the request fields are registered and the FSM goes to REQ.
- REQ:
  - `dmem_req_valid` = 1; `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb` are held stable until `dmem_req_ready` = 1.
  - On acceptance, a store goes to DONE and a load goes to RESP.
- RESP: waits for `dmem_rsp_valid`; the extended data is captured into `readData_M` and the FSM goes to DONE.
- DONE: `stall_M` = 0 (the same instruction is still in MEM this cycle). The FSM goes to IDLE unconditionally.
- `stall_M` = 1 in IDLE with a legal access, and in REQ and RESP.
- Store lanes, with `o = addr[1:0]`:
  - SB: wstrb = `1<<o`; wdata = byte replicated ×4.
  - SH: wstrb = `0011` if `addr[1]` = 0, else `1100`; wdata = halfword replicated ×2.
  - SW: wstrb = `1111`; wdata = writeData_M.
- Load extract: byte `rdata[8o+:8]`, halfword `rdata[16*addr[1]+:16]`. LB/LH sign-extend; LBU/LHU zero-extend.
- `readData_M` is registered:
  - It holds its value until the next load completes.
  - It is set to 0 on a timeout and on a fault.
- Timeout:
  - An 8-bit-or-wider counter clears on entry to REQ and to RESP, and increments each cycle in those states.
  - When the count reaches `MAX_WAIT`, the FSM goes to DONE with `timeout_M` = 1 for the DONE cycle and `readData_M` = 0.
  - `MAX_WAIT` = 0 disables the timeout.
- `dmem_rsp_valid` in IDLE, REQ or DONE is ignored. This covers stray or late responses.

## Timing
- Reset (asynchronous, `reset` = 0):
  - FSM goes to IDLE; counter and `readData_M` = 0.
  - `dmem_req_valid`, `dmem_we`, `dmem_wstrb`, `stall_M`, `timeout_M` = 0; `dmem_addr` and `dmem_wdata` = 0.
  - A reset taken mid-access abandons it; the response to an already-accepted load is ignored.
- Store with `ready` = 1 on the first REQ cycle: IDLE → REQ → DONE; `stall_M` is high for 2 cycles.
- Load with `ready` = 1 and `rsp_valid` one cycle later: IDLE → REQ → RESP → DONE; `stall_M` is high for 3 cycles; data is valid in DONE.
- Each additional cycle of `ready` = 0 or `rsp_valid` = 0 adds one stall cycle.
- `dmem_req_valid` never drops before acceptance.
- At most one request is outstanding.
- A request is never issued in DONE, so back-to-back accesses have one non-stalled cycle between them.

## Test plan
- SW to addr 0x100, data 0xDEADBEEF, `ready` = 1 → one request with we = 1, addr 0x100, wstrb 1111, wdata 0xDEADBEEF; `stall_M` high for 2 cycles.
- SB to 0x103, data 0x000000A5 → wstrb 1000, wdata 0xA5A5A5A5. SH to 0x102, data 0x1234 → wstrb 1100, wdata 0x12341234.
- LB from 0x101 with rdata 0x0000_80FF, then LBU from the same address → `readData_M` 0xFFFFFF80, then 0x00000080. LHU from 0x102 with rdata 0xBEEF0000 → 0x0000BEEF.
- LW with `ready` low for 3 cycles and `rsp_valid` 2 cycles after acceptance → `stall_M` high for 7 cycles, request fields stable throughout, correct data in DONE.
- LW to 0x102 → `access_fault_M` = 1 for 1 cycle, no `dmem_req_valid`, `stall_M` = 0. Load with funct3 = 3 → same response.
- `MAX_WAIT` = 4, `rsp_valid` never asserted → `timeout_M` pulses and `readData_M` = 0. Separately, assert reset in RESP, then `rsp_valid` → FSM in IDLE, all outputs 0, and the response is ignored.
